// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared types, edge codes and screen limits for the ghost fleet mover
package ghost_pkg;

    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
    typedef enum logic {RANDOM = 1'b0, CHASE = 1'b1} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_DONE} state_t;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 2;
    localparam int EDGE_TOP    = 3;
    localparam int EDGE_CORNER = 4;
    localparam int NUM_EDGES   = 5;

    localparam int COORD_W       = 11;
    localparam int SCREEN_X_LAST = 639;
    localparam int SCREEN_Y_LAST = 479;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic is_blocked(input dir_t d, input logic [NUM_EDGES-1:0] hit);
        return hit[EDGE_CORNER]
            | (hit[EDGE_TOP]    & (d == UP))
            | (hit[EDGE_BOTTOM] & (d == DOWN))
            | (hit[EDGE_LEFT]   & (d == LEFT))
            | (hit[EDGE_RIGHT]  & (d == RIGHT));
    endfunction

endpackage

// File: rtl/ghost_turn_logic.sv
// rtl/ghost_turn_logic.sv - combinational turn decision for the ghost being updated
module ghost_turn_logic
    import ghost_pkg::*;
(
    input  dir_t                      dir,
    input  logic [NUM_EDGES-1:0]      hit,
    input  mode_t                     mode,
    input  logic                      frightened,
    input  logic [1:0]                lfsr_bits,
    input  logic signed [COORD_W-1:0] ghost_x,
    input  logic signed [COORD_W-1:0] ghost_y,
    input  logic signed [COORD_W-1:0] pac_x,
    input  logic signed [COORD_W-1:0] pac_y,
    output dir_t                      new_dir,
    output logic                      lfsr_step
);

    dir_t cand;

    always_comb begin
        cand      = dir_t'(lfsr_bits);
        new_dir   = dir;
        lfsr_step = 1'b0;
        if (is_blocked(dir, hit)) begin
            if (frightened || mode == RANDOM) begin
                lfsr_step = 1'b1;
                new_dir   = is_blocked(cand, hit) ? reverse_dir(dir) : cand;
            end else if (hit[EDGE_CORNER]) begin
                new_dir = reverse_dir(dir);
            end else if (dir == LEFT || dir == RIGHT) begin
                new_dir = (pac_y < ghost_y) ? UP : DOWN;
            end else begin
                new_dir = (pac_x < ghost_x) ? LEFT : RIGHT;
            end
        end
    end

endmodule

// File: rtl/ghost_fleet_move.sv
// rtl/ghost_fleet_move.sv - time-multiplexed mover for all ghosts; GHOST_TUNNEL_EN wraps X instead of clamping
module ghost_fleet_move
    import ghost_pkg::*;
#(
    parameter int                    NUM_GHOSTS    = 4,
    parameter int                    FP_SHIFT      = 6,
    parameter int                    SPEED         = 60,
    parameter int                    INIT_X        = 280,
    parameter int                    INIT_Y        = 185,
    parameter int                    SPACING       = 40,
    parameter logic [NUM_GHOSTS-1:0] CHASE_MASK    = NUM_GHOSTS'(4'b0101),
    parameter int                    FRIGHT_FRAMES = 180,
    parameter int                    OBJ_W         = 32,
    parameter int                    OBJ_H         = 32,
    parameter int                    MARGIN        = 2
)(
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic [NUM_GHOSTS-1:0]            collision,
    input  logic [3*NUM_GHOSTS-1:0]          HitEdgeCode,
    input  logic                             frightenPulse,
    input  logic [NUM_GHOSTS-1:0]            ghostEaten,
    input  logic signed [COORD_W-1:0]        pacX,
    input  logic signed [COORD_W-1:0]        pacY,
    output logic signed [COORD_W*NUM_GHOSTS-1:0] topLeftX,
    output logic signed [COORD_W*NUM_GHOSTS-1:0] topLeftY,
    output logic [NUM_GHOSTS-1:0]            frightened,
    output logic                             frameDone
);

    localparam int POS_W   = COORD_W + FP_SHIFT + 1;
    localparam int IDX_W   = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int TIMER_W = $clog2(FRIGHT_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GHOSTS - 1);

    localparam logic signed [POS_W-1:0] X_MIN      = POS_W'(MARGIN << FP_SHIFT);
    localparam logic signed [POS_W-1:0] X_MAX      = POS_W'((SCREEN_X_LAST - MARGIN - OBJ_W) << FP_SHIFT);
    localparam logic signed [POS_W-1:0] Y_MIN      = POS_W'(MARGIN << FP_SHIFT);
    localparam logic signed [POS_W-1:0] Y_MAX      = POS_W'((SCREEN_Y_LAST - MARGIN - OBJ_H) << FP_SHIFT);
    localparam logic signed [POS_W-1:0] HOME_Y     = POS_W'(INIT_Y << FP_SHIFT);
    localparam logic signed [POS_W-1:0] SPEED_NORM = POS_W'(SPEED);
    localparam logic signed [POS_W-1:0] SPEED_SLOW = POS_W'(SPEED >>> 1);

    function automatic logic signed [POS_W-1:0] home_x(input int i);
        return POS_W'((INIT_X + i * SPACING) << FP_SHIFT);
    endfunction

    function automatic dir_t home_dir(input int i);
        return i[0] ? LEFT : RIGHT;
    endfunction

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx;
    logic                    upd_en, last_ghost;
    logic [NUM_GHOSTS-1:0]   upd_sel;

    logic signed [POS_W-1:0] pos_x   [NUM_GHOSTS];
    logic signed [POS_W-1:0] pos_y   [NUM_GHOSTS];
    dir_t                    dir_q   [NUM_GHOSTS];
    logic [NUM_EDGES-1:0]    hit_q   [NUM_GHOSTS];
    logic [NUM_EDGES-1:0]    new_hit [NUM_GHOSTS];
    logic [TIMER_W-1:0]      timer_q [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0]   fright_q, pend_q;
    logic [7:0]              lfsr;
    logic                    frame_done_q;

    logic signed [POS_W-1:0]   cur_x, cur_y, speed, vel_x, vel_y, next_x, next_y;
    logic signed [COORD_W-1:0] cur_ix, cur_iy;
    dir_t                      cur_dir, new_dir;
    mode_t                     cur_mode;
    logic                      lfsr_step;
    logic [TIMER_W-1:0]        timer_dec;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (startOfFrame) state_next = S_WAIT;
            S_WAIT:   if (startOfFrame) state_next = S_UPDATE;
            S_UPDATE: if (last_ghost)   state_next = S_DONE;
            S_DONE:   state_next = S_WAIT;
        endcase
    end

    always_comb begin
        upd_en     = (state == S_UPDATE);
        last_ghost = upd_en && (idx == LAST_IDX);
        for (int i = 0; i < NUM_GHOSTS; i++)
            upd_sel[i] = upd_en && (idx == IDX_W'(i));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            idx          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_ghost;
            if (state == S_WAIT)
                idx <= '0;
            else if (upd_en)
                idx <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            new_hit[i] = '0;
            if (collision[i] && HitEdgeCode[3*i +: 3] < 3'd5)
                new_hit[i][HitEdgeCode[3*i +: 3]] = 1'b1;
        end
    end

    // Shared datapath: everything below works on the ghost selected by idx
    assign cur_x     = pos_x[idx];
    assign cur_y     = pos_y[idx];
    assign cur_ix    = cur_x[FP_SHIFT +: COORD_W];
    assign cur_iy    = cur_y[FP_SHIFT +: COORD_W];
    assign cur_dir   = pend_q[idx] ? reverse_dir(dir_q[idx]) : dir_q[idx];
    assign cur_mode  = CHASE_MASK[idx] ? CHASE : RANDOM;
    assign speed     = fright_q[idx] ? SPEED_SLOW : SPEED_NORM;
    assign timer_dec = timer_q[idx] - TIMER_W'(1);

    ghost_turn_logic u_turn (
        .dir        (cur_dir),
        .hit        (hit_q[idx]),
        .mode       (cur_mode),
        .frightened (fright_q[idx]),
        .lfsr_bits  (lfsr[1:0]),
        .ghost_x    (cur_ix),
        .ghost_y    (cur_iy),
        .pac_x      (pacX),
        .pac_y      (pacY),
        .new_dir    (new_dir),
        .lfsr_step  (lfsr_step)
    );

    always_comb begin
        vel_x = '0;
        vel_y = '0;
        case (new_dir)
            UP:    vel_y = -speed;
            DOWN:  vel_y = speed;
            LEFT:  vel_x = -speed;
            RIGHT: vel_x = speed;
        endcase
        next_x = cur_x + vel_x;
        next_y = cur_y + vel_y;
`ifdef GHOST_TUNNEL_EN
        if (next_x < X_MIN)      next_x = X_MAX;
        else if (next_x > X_MAX) next_x = X_MIN;
`else
        if (next_x < X_MIN)      next_x = X_MIN;
        else if (next_x > X_MAX) next_x = X_MAX;
`endif
        if (next_y < Y_MIN)      next_y = Y_MIN;
        else if (next_y > Y_MAX) next_y = Y_MAX;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            lfsr <= LFSR_SEED;
        else if (upd_en && lfsr_step)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                pos_x[i]   <= home_x(i);
                pos_y[i]   <= HOME_Y;
                dir_q[i]   <= home_dir(i);
                hit_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            fright_q <= '0;
            pend_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_GHOSTS; i++) begin
                if (ghostEaten[i]) begin
                    pos_x[i]    <= home_x(i);
                    pos_y[i]    <= HOME_Y;
                    dir_q[i]    <= home_dir(i);
                    hit_q[i]    <= '0;
                    timer_q[i]  <= '0;
                    fright_q[i] <= 1'b0;
                    pend_q[i]   <= 1'b0;
                end else begin
                    hit_q[i] <= (upd_sel[i] ? '0 : hit_q[i]) | new_hit[i];
                    if (upd_sel[i]) begin
                        pos_x[i]  <= next_x;
                        pos_y[i]  <= next_y;
                        dir_q[i]  <= new_dir;
                        pend_q[i] <= 1'b0;
                        if (fright_q[i]) begin
                            timer_q[i] <= timer_dec;
                            if (timer_dec == '0) fright_q[i] <= 1'b0;
                        end
                    end
                    // Only a ghost entering fright owes a reversal; a reload does not
                    if (frightenPulse) begin
                        timer_q[i]  <= TIMER_W'(FRIGHT_FRAMES);
                        fright_q[i] <= 1'b1;
                        pend_q[i]   <= ~fright_q[i] | (pend_q[i] & ~upd_sel[i]);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_out
        assign topLeftX[g*COORD_W +: COORD_W] = pos_x[g][FP_SHIFT +: COORD_W];
        assign topLeftY[g*COORD_W +: COORD_W] = pos_y[g][FP_SHIFT +: COORD_W];
    end

    assign frightened = fright_q;
    assign frameDone  = frame_done_q;

endmodule

// File: tb/tb_ghost_fleet_move.sv
// tb/tb_ghost_fleet_move.sv - directed and random frames checked against a frame-level fleet model
module tb_ghost_fleet_move;

    localparam int N = 4;

    logic                    clk = 1'b0;
    logic                    resetN = 1'b0;
    logic                    startOfFrame = 1'b0;
    logic                    frightenPulse = 1'b0;
    logic [N-1:0]            collision = '0;
    logic [N-1:0]            ghostEaten = '0;
    logic [3*N-1:0]          HitEdgeCode = '0;
    logic signed [10:0]      pacX = '0;
    logic signed [10:0]      pacY = '0;
    logic signed [11*N-1:0]  topLeftX, topLeftY;
    logic [N-1:0]            frightened;
    logic                    frameDone;

    int total = 0;
    int bad = 0;

    int mx[N], my[N], md[N], mhit[N], mt[N], mf[N], mp[N];
    int mlfsr;

    ghost_fleet_move dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .collision     (collision),
        .HitEdgeCode   (HitEdgeCode),
        .frightenPulse (frightenPulse),
        .ghostEaten    (ghostEaten),
        .pacX          (pacX),
        .pacY          (pacY),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .frightened    (frightened),
        .frameDone     (frameDone)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int getx(input int i);
        return int'($signed(topLeftX[i*11 +: 11]));
    endfunction

    function automatic int gety(input int i);
        return int'($signed(topLeftY[i*11 +: 11]));
    endfunction

    // dirs: 0 up, 1 down, 2 left, 3 right; hit mask bit = edge code
    function automatic bit blocked(input int d, input int h);
        return ((h >> 4) & 1) == 1
            || (d == 0 && ((h >> 3) & 1) == 1)
            || (d == 1 && (h & 1) == 1)
            || (d == 2 && ((h >> 1) & 1) == 1)
            || (d == 3 && ((h >> 2) & 1) == 1);
    endfunction

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    task automatic model_home(input int i);
        mx[i] = (280 + 40 * i) * 64;
        my[i] = 185 * 64;
        md[i] = (i % 2 == 1) ? 2 : 3;
        mhit[i] = 0; mt[i] = 0; mf[i] = 0; mp[i] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_home(i);
        mlfsr = 165;
    endtask

    task automatic model_frame(input int px, input int py);
        for (int i = 0; i < N; i++) begin
            int d, sp, cand;
            d = mp[i] ? 1 - (md[i] % 2) + 2 * (md[i] / 2) : md[i];
            mp[i] = 0;
            if (blocked(d, mhit[i])) begin
                if (mf[i] == 1 || ((5 >> i) & 1) == 0) begin
                    cand = mlfsr % 4;
                    mlfsr = lfsr_next(mlfsr);
                    d = blocked(cand, mhit[i]) ? 1 - (d % 2) + 2 * (d / 2) : cand;
                end else if ((mhit[i] & 16) != 0) d = 1 - (d % 2) + 2 * (d / 2);
                else if (d >= 2) d = (py < my[i] / 64) ? 0 : 1;
                else d = (px < mx[i] / 64) ? 2 : 3;
            end
            sp = mf[i] ? 60 / 2 : 60;
            case (d)
                0: my[i] -= sp;
                1: my[i] += sp;
                2: mx[i] -= sp;
                default: mx[i] += sp;
            endcase
`ifdef GHOST_TUNNEL_EN
            if (mx[i] < 2 * 64) mx[i] = 605 * 64;
            else if (mx[i] > 605 * 64) mx[i] = 2 * 64;
`else
            if (mx[i] < 2 * 64) mx[i] = 2 * 64;
            else if (mx[i] > 605 * 64) mx[i] = 605 * 64;
`endif
            if (my[i] < 2 * 64) my[i] = 2 * 64;
            else if (my[i] > 445 * 64) my[i] = 445 * 64;
            md[i] = d;
            mhit[i] = 0;
            if (mf[i] == 1) begin
                mt[i]--;
                if (mt[i] == 0) mf[i] = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_x%0d", tag, i), getx(i), mx[i] / 64);
            chk($sformatf("%s_y%0d", tag, i), gety(i), my[i] / 64);
            chk($sformatf("%s_fr%0d", tag, i), int'(frightened[i]), mf[i]);
        end
    endtask

    task automatic drive_events(input logic [N-1:0] col, input logic [3*N-1:0] codes,
                                input logic [N-1:0] eat, input logic fp);
        collision = col; HitEdgeCode = codes; ghostEaten = eat; frightenPulse = fp;
        for (int i = 0; i < N; i++) begin
            if (col[i] && codes[3*i +: 3] < 3'd5) mhit[i] |= 1 << codes[3*i +: 3];
            if (fp) begin
                if (mf[i] == 0) mp[i] = 1;
                mt[i] = 180;
                mf[i] = 1;
            end
            if (eat[i]) model_home(i);
        end
        @(negedge clk);
        collision = '0; HitEdgeCode = '0; ghostEaten = '0; frightenPulse = 1'b0;
    endtask

    task automatic run_frame(input bit extra_sof);
        int lat;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        lat = 1;
        while (frameDone !== 1'b1 && lat < 20) begin
            startOfFrame = extra_sof && lat == 1;
            @(negedge clk);
            lat++;
        end
        startOfFrame = 1'b0;
        chk("done_latency", lat, N + 1);
        @(negedge clk);
        chk("done_width", int'(frameDone), 0);
        model_frame(int'(pacX), int'(pacY));
        check_all("frame");
    endtask

    initial begin
        int seen;
        logic [N-1:0] rc, re;
        logic [3*N-1:0] rcode;

        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_done", int'(frameDone), 0);
        resetN = 1'b1;
        @(negedge clk);

        // first startOfFrame only arms the sequencer
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (frameDone === 1'b1) seen = 1;
        end
        chk("idle_no_done", seen, 0);
        check_all("idle_hold");

        pacX = 11'sd320; pacY = 11'sd400;
        run_frame(0);
        chk("g0_x_f1", getx(0), 280);
        run_frame(0);
        chk("g0_x_f2", getx(0), 281);

        drive_events(4'b0010, 12'b000_000_001_000, '0, 1'b0);
        run_frame(0);

        pacY = 11'sd100;
        drive_events(4'b0001, 12'b000_000_000_010, '0, 1'b0);
        run_frame(0);
        chk("chase_up_y1", gety(0), 184);
        run_frame(0);
        chk("chase_up_y2", gety(0), 183);

        run_frame(1);

        drive_events('0, '0, '0, 1'b1);
        chk("fright_all", int'(frightened), 15);
        for (int f = 0; f < 180; f++) run_frame(0);
        chk("fright_over", int'(frightened), 0);

        drive_events(4'b0100, '0, 4'b0100, 1'b1);
        chk("eat_x2", getx(2), 360);
        chk("eat_y2", gety(2), 185);
        chk("eat_fr", int'(frightened), 11);
        for (int f = 0; f < 3; f++) run_frame(0);

        // send ghost 0 leftwards into the left wall
        drive_events('0, '0, 4'b0001, 1'b0);
        drive_events('0, '0, '0, 1'b1);
        for (int f = 0; f < 420; f++) run_frame(0);
`ifdef GHOST_TUNNEL_EN
        chk("wall_x0", getx(0), mx[0] / 64);
`else
        chk("wall_x0", getx(0), 2);
`endif

        for (int f = 0; f < 150; f++) begin
            pacX = 11'($urandom_range(0, 639));
            pacY = 11'($urandom_range(0, 479));
            rc = '0; re = '0; rcode = '0;
            for (int i = 0; i < N; i++) begin
                rc[i] = ($urandom_range(0, 99) < 35);
                re[i] = ($urandom_range(0, 99) < 4);
                rcode[3*i +: 3] = 3'($urandom_range(0, 4));
            end
            drive_events(rc, rcode, re, $urandom_range(0, 99) < 4);
            run_frame($urandom_range(0, 9) == 0);
        end

        // reset in the middle of a frame aborts it
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("abort");
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (frameDone === 1'b1) seen = 1;
        end
        chk("abort_no_done", seen, 0);
        resetN = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
        run_frame(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
